// File: rtl/microcode_pkg.sv
// ---------------------------------------------------------------------------
// microcode_pkg
// Shared types and sizing helpers for the microcode loader slice.
//   loader_state_e  : loader FSM state encoding
//   mc_word_width   : microcode word width from control/state field widths
//   bytes_per_word  : number of host bytes needed to carry one word
// ---------------------------------------------------------------------------
package microcode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_e;

    // A word carries the control field plus current-state and next-state fields.
    function automatic int mc_word_width(input int ctl, input int st);
        return ctl + 2 * st;
    endfunction

    // Bytes needed to cover w bits; the unused top bits of the last byte are dropped.
    function automatic int bytes_per_word(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/microcode_word_assembler.sv
// ---------------------------------------------------------------------------
// microcode_word_assembler
// Little-endian byte packer: byte k of a word lands in bits [8k+7:8k].
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear_i         drop any partial word, restart at byte 0
//   shift_i         a byte is accepted this cycle
//   byte_i[7:0]     accepted byte
//   word_full_o     this accepted byte completes the word
//   word_next_o     assembled word including the byte on byte_i
// ---------------------------------------------------------------------------
module microcode_word_assembler #(
    parameter int W   = 40,
    parameter int BPW = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         shift_i,
    input  logic [7:0]   byte_i,
    output logic         word_full_o,
    output logic [W-1:0] word_next_o
);

    localparam int IW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AW = 8 * BPW;
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

    logic [AW-1:0] asm_q;
    logic [AW-1:0] asm_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [AW-1:0] merged_s;

    // Merge the incoming byte into its lane so the top level can register the
    // finished word on the same edge that accepts its final byte.
    always_comb begin
        merged_s = asm_q;
        merged_s[8 * idx_q +: 8] = byte_i;
        word_full_o = shift_i && (idx_q == LAST_IDX);
        word_next_o = merged_s[W-1:0];
    end

    // Next-state for the assembly buffer and byte index.
    always_comb begin
        asm_d = asm_q;
        idx_d = idx_q;
        if (clear_i) begin
            asm_d = '0;
            idx_d = '0;
        end else if (shift_i) begin
            asm_d = merged_s;
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            asm_d = asm_q;
            idx_d = idx_q;
        end
    end

    // Assembly buffer and byte index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/microcode_loader.sv
// ---------------------------------------------------------------------------
// microcode_loader
// Packs a host byte stream into microcode words and strobes each word into
// the microcode store; exactly NUM_WORDS writes per session, then done.
// Optional feature macro: CHECKSUM_EN -- one trailing byte after the last
// word; the 8-bit sum of all session bytes plus it must be 8'h00, otherwise
// error is raised (words are still written).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a session (ignored while busy)
//   in_data/in_valid/in_ready  host byte stream handshake
//   smdata_word     assembled word, held between strobes
//   smload          one-cycle write strobe to the store
//   word_count      words written this session
//   busy/done/error session status; done/error held until next start
// ---------------------------------------------------------------------------
module microcode_loader
    import microcode_pkg::*;
#(
    parameter int NUM_ADDRESS_LINES = 5,
    parameter int NUM_WORDS         = 32,
    parameter int NUM_STATE_BITS    = 4,
    parameter int NUM_CONTROL_BITS  = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [7:0]                                   in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic [NUM_CONTROL_BITS+2*NUM_STATE_BITS-1:0] smdata_word,
    output logic                                         smload,
    output logic [NUM_ADDRESS_LINES:0]                   word_count,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         error
);

    localparam int W   = mc_word_width(NUM_CONTROL_BITS, NUM_STATE_BITS);
    localparam int BPW = bytes_per_word(W);
    localparam int CW  = NUM_ADDRESS_LINES + 1;
    localparam logic [CW-1:0] NUM_WORDS_C = CW'(NUM_WORDS);

    loader_state_e state_q;
    loader_state_e state_d;
    logic [CW-1:0] word_count_q;
    logic [CW-1:0] word_count_d;
    logic [W-1:0]  smdata_q;
    logic [W-1:0]  smdata_d;
    logic          smload_q;
    logic          smload_d;
    logic          in_ready_q;
    logic          in_ready_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;
    logic          error_q;
    logic          error_d;

    logic          accept_s;
    logic          shift_s;
    logic          clear_s;
    logic          word_full_s;
    logic [W-1:0]  word_next_s;
    logic [CW-1:0] count_inc_s;

    // in_ready_q mirrors "state is COLLECT or CHECK", so it qualifies transfers.
    assign accept_s    = in_valid && in_ready_q;
    assign shift_s     = accept_s && (state_q == ST_COLLECT);
    assign clear_s     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                   (state_q == ST_ERROR));
    assign count_inc_s = word_count_q + CW'(1);

    microcode_word_assembler #(
        .W   (W),
        .BPW (BPW)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_s),
        .shift_i     (shift_s),
        .byte_i      (in_data),
        .word_full_o (word_full_s),
        .word_next_o (word_next_s)
    );

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic [7:0] sum_next_s;

    assign sum_next_s = sum_q + in_data;

    // Running modulo-256 sum of every byte accepted this session.
    always_comb begin
        sum_d = sum_q;
        if (clear_s) begin
            sum_d = 8'h00;
        end else if (accept_s) begin
            sum_d = sum_next_s;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // FSM next state, word counter and write strobe/data.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        smdata_d     = smdata_q;
        smload_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_COLLECT;
                    word_count_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COLLECT: begin
                if (word_full_s) begin
                    state_d  = ST_WRITE;
                    smdata_d = word_next_s;
                    smload_d = 1'b1;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                // Count advances on the edge that ends the strobe, i.e. when
                // the store latches the word.
                word_count_d = count_inc_s;
                if (count_inc_s < NUM_WORDS_C) begin
                    state_d = ST_COLLECT;
                end else begin
`ifdef CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
`ifdef CHECKSUM_EN
                if (accept_s) begin
                    if (sum_next_s == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state register.
        in_ready_d = (state_d == ST_COLLECT) || (state_d == ST_CHECK);
        busy_d     = (state_d == ST_COLLECT) || (state_d == ST_WRITE) ||
                     (state_d == ST_CHECK);
        done_d     = (state_d == ST_DONE);
`ifdef CHECKSUM_EN
        error_d    = (state_d == ST_ERROR);
`else
        error_d    = 1'b0;
`endif
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            smdata_q     <= '0;
            smload_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            smdata_q     <= smdata_d;
            smload_q     <= smload_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign smdata_word = smdata_q;
    assign smload      = smload_q;
    assign word_count  = word_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_microcode_loader.sv
// ---------------------------------------------------------------------------
// tb_microcode_loader
// Scoreboard bench: the driver packs accepted bytes into expected words and
// queues them; an independent monitor pops and compares on every smload.
// Build with +define+CHECKSUM_EN to exercise the trailing-checksum sessions.
// ---------------------------------------------------------------------------
module tb_microcode_loader;

    localparam int W   = 40;
    localparam int BPW = 5;
    localparam int NW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  smdata_word;
    logic          smload;
    logic [5:0]    word_count;
    logic          busy;
    logic          done;
    logic          error;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            pulse_cnt = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  last_word;

    microcode_loader #(
        .NUM_ADDRESS_LINES (5),
        .NUM_WORDS         (NW),
        .NUM_STATE_BITS    (4),
        .NUM_CONTROL_BITS  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .smdata_word (smdata_word),
        .smload      (smload),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next queued word.
    always @(negedge clk) begin
        if (rst === 1'b0 && smload === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_smload", {63'd0, smload}, 64'd0);
            end else begin
                check("smdata_word", {24'd0, smdata_word}, {24'd0, exp_q.pop_front()});
                check("word_count_during_write", {58'd0, word_count}, 64'(pulse_cnt));
                check("in_ready_low_in_write", {63'd0, in_ready}, 64'd0);
                pulse_cnt++;
            end
        end
    end

    // mode: 0 random bytes, 1 bytes 01,02,..., 2 all 8'h01.
    // abort_after >= 0: reset after that many accepted bytes.
    task automatic run_session(input int mode, input int valid_pct, input int start_at,
                               input int abort_after, input int sum_offset);
        logic [7:0] b;
        logic [7:0] sum;
        logic [W-1:0] w;
        int k;
        int cyc;
        int limit;
        bit exp_err;
        k = 0;
        cyc = 0;
        sum = 8'h00;
        w = '0;
        exp_err = 1'b0;
        limit = (abort_after >= 0) ? abort_after : NW * BPW;
        @(negedge clk);
        pulse_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("done_cleared_on_start", {63'd0, done}, 64'd0);
        check("count_cleared_on_start", {58'd0, word_count}, 64'd0);
        while (k < limit && cyc < 5000) begin
            case (mode)
                1:       b = 8'(k + 1);
                2:       b = 8'h01;
                default: b = 8'($urandom);
            endcase
            in_data  = b;
            in_valid = ($urandom_range(99) < valid_pct);
            start    = (k == start_at);
            if (in_valid && in_ready) begin
                w[8 * (k % BPW) +: 8] = b;
                sum = sum + b;
                k++;
                if (k % BPW == 0) begin
                    exp_q.push_back(w);
                    last_word = w;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("bytes_accepted_in_budget", 64'(k), 64'(limit));
        if (abort_after >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("abort_smload", {63'd0, smload}, 64'd0);
            check("abort_busy", {63'd0, busy}, 64'd0);
            check("abort_in_ready", {63'd0, in_ready}, 64'd0);
            check("abort_word_count", {58'd0, word_count}, 64'd0);
            check("abort_smdata", {24'd0, smdata_word}, 64'd0);
            rst = 1'b0;
            exp_q.delete();
            in_valid = 1'b1;
            repeat (12) @(negedge clk);
            in_valid = 1'b0;
            check("abort_stays_idle", {62'd0, busy, in_ready}, 64'd0);
            check("abort_no_new_pulses", {58'd0, word_count}, 64'd0);
        end else begin
`ifdef CHECKSUM_EN
            exp_err = (sum_offset != 0);
            in_data = 8'(8'h00 - sum + 8'(sum_offset));
            in_valid = 1'b1;
            cyc = 0;
            while (!in_ready && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check("trailing_byte_ready", {63'd0, in_ready}, 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
`endif
            cyc = 0;
            while (!done && !error && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check("done", {63'd0, done}, {63'd0, !exp_err});
            check("error", {63'd0, error}, {63'd0, exp_err});
            check("final_word_count", {58'd0, word_count}, 64'(NW));
            check("final_busy", {63'd0, busy}, 64'd0);
            check("final_in_ready", {63'd0, in_ready}, 64'd0);
            check("pulse_count", 64'(pulse_cnt), 64'(NW));
            check("queue_drained", 64'(exp_q.size()), 64'd0);
            check("smdata_held", {24'd0, smdata_word}, {24'd0, last_word});
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        last_word = '0;
        repeat (3) @(negedge clk);
        check("reset_smload", {63'd0, smload}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        check("reset_status", {61'd0, busy, done, error}, 64'd0);
        check("reset_word_count", {58'd0, word_count}, 64'd0);
        check("reset_smdata", {24'd0, smdata_word}, 64'd0);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_during_reset_ignored", {63'd0, busy}, 64'd0);
        check("idle_not_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;

        run_session(1, 100, -1, -1, 0);   // sequential bytes, word 0 = 40'h0504030201
        run_session(0, 50, -1, -1, 0);    // backpressure
        run_session(0, 100, 7, -1, 0);    // start while busy
        run_session(0, 100, -1, 13, 0);   // reset mid-load
        run_session(0, 70, -1, -1, 0);    // clean reload after abort
`ifdef CHECKSUM_EN
        run_session(2, 100, -1, -1, 0);   // 160 x 8'h01 + 8'h60
        run_session(2, 100, -1, -1, 1);   // trailing 8'h61
        run_session(0, 60, -1, -1, 0);    // recovery after error
`endif
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
